// File: rtl/bsg_trace_recorder_pkg.sv
// bsg_trace_recorder_pkg
//   Shared definitions for the trace recorder:
//     - trace record opcodes (SEND, FINISH, WAIT), matching bsg_trace_replay
//     - recorder FSM state enum
//     - BSG_TRACE_RECORD_T(pw): packed {op[3:0], payload[pw-1:0]} record type.
//       A package cannot take parameters, so each user instantiates the
//       record type at its own payload width through this macro.
//   No ports.

`ifndef BSG_TRACE_RECORDER_PKG_SV
`define BSG_TRACE_RECORDER_PKG_SV

`define BSG_TRACE_RECORD_T(pw) struct packed { logic [3:0] op; logic [(pw)-1:0] payload; }

package bsg_trace_recorder_pkg;

   localparam logic [3:0] op_send_c   = 4'b0001;
   localparam logic [3:0] op_finish_c = 4'b0100;
   localparam logic [3:0] op_wait_c   = 4'b0101;

   typedef enum logic [2:0] {
      REC       = 3'd0,
      EMIT_WAIT = 3'd1,
      EMIT_SEND = 3'd2,
      EMIT_FIN  = 3'd3,
      DONE      = 3'd4
   } state_e;

endpackage

`endif

// File: rtl/bsg_trace_recorder_gap_ctr.sv
// bsg_trace_recorder_gap_ctr
//   Saturating idle-cycle counter. Clear has priority over enable; the count
//   sticks at all-ones instead of wrapping so a very long gap is recorded as
//   the largest representable delay.
//   Ports:
//     clk_i    clock
//     reset_i  asynchronous active-high reset (count -> 0)
//     en_i     count one more idle cycle
//     clr_i    restart from zero
//     count_o  current count

module bsg_trace_recorder_gap_ctr #(
   parameter int width_p = 10
) (
   input  logic               clk_i,
   input  logic               reset_i,
   input  logic               en_i,
   input  logic               clr_i,
   output logic [width_p-1:0] count_o
);

   localparam logic [width_p-1:0] one_lp = width_p'(1);

   logic [width_p-1:0] count_r;

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         count_r <= '0;
      end else if (clr_i) begin
         count_r <= '0;
      end else if (en_i && (count_r != '1)) begin
         count_r <= count_r + one_lp;
      end
   end

   assign count_o = count_r;

endmodule

// File: rtl/bsg_trace_recorder.sv
// bsg_trace_recorder
//   Captures a valid/ready payload stream into a trace memory as
//   {op[3:0], payload} records readable by bsg_trace_replay. Each accepted
//   payload becomes a SEND record, the trace is closed with a FINISH record.
//   Build option BSG_TRACE_RECORDER_GAP_EN: when defined, idle cycles between
//   accepts are counted and emitted as a WAIT record ahead of the next SEND.
//   Ports:
//     clk_i, reset_i   clock, asynchronous active-high reset
//     en_i             recording enable (no accepts, gap counter holds when 0)
//     v_i, data_i      input payload stream
//     ready_o          input accepted when v_i & ready_o
//     finish_i         one-cycle request to close the trace
//     mem_v_o, mem_addr_o, mem_data_o, mem_ready_i
//                      trace-memory write port
//     count_o          records written (saturates at 2^mem_addr_width_p-1)
//     done_o           trace closed (sticky until reset)
//     overflow_o       trace closed because capacity ran out
//
// Handshakes: a transfer happens on a rising clock edge where valid & ready
// are both 1. ready_o depends only on state, address and en_i, never on v_i.
// mem_v_o/mem_addr_o/mem_data_o come straight from registers and hold while
// mem_v_o & !mem_ready_i.

module bsg_trace_recorder
   import bsg_trace_recorder_pkg::*;
#(
   parameter int payload_width_p  = 10,
   parameter int mem_addr_width_p = 16
) (
   input  logic                        clk_i,
   input  logic                        reset_i,
   input  logic                        en_i,
   input  logic                        v_i,
   input  logic [payload_width_p-1:0]  data_i,
   output logic                        ready_o,
   input  logic                        finish_i,
   output logic                        mem_v_o,
   output logic [mem_addr_width_p-1:0] mem_addr_o,
   output logic [payload_width_p+3:0]  mem_data_o,
   input  logic                        mem_ready_i,
   output logic [mem_addr_width_p-1:0] count_o,
   output logic                        done_o,
   output logic                        overflow_o
);

   typedef `BSG_TRACE_RECORD_T(payload_width_p) record_t;

   localparam int depth_lp = 1 << mem_addr_width_p;
   // Room kept free so a full WAIT/SEND pair (or SEND alone) plus FINISH
   // always fits after the last accept.
`ifdef BSG_TRACE_RECORDER_GAP_EN
   localparam int reserve_lp = 3;
`else
   localparam int reserve_lp = 2;
`endif
   // One extra address bit: after the final FINISH the address can equal depth.
   localparam logic [mem_addr_width_p:0] addr_limit_lp = (mem_addr_width_p+1)'(depth_lp - reserve_lp);
   localparam logic [mem_addr_width_p:0] addr_one_lp   = (mem_addr_width_p+1)'(1);

   state_e                        state_r, state_n;
   logic [mem_addr_width_p:0]     addr_r, addr_n;
   logic                          fin_r, fin_n;
   logic                          ovf_pend_r, ovf_pend_n;
   logic                          ovf_r, ovf_n;
   logic                          mem_v_r, mem_v_n;
   logic [mem_addr_width_p-1:0]   mem_addr_r, mem_addr_n;
   record_t                       mem_rec_r, mem_rec_n;
   logic                          accept;
   logic                          fin_req;

   assign ready_o = en_i & (state_r == REC) & (addr_r <= addr_limit_lp);
   assign accept  = v_i & ready_o;
   assign fin_req = fin_r | finish_i;

`ifdef BSG_TRACE_RECORDER_GAP_EN
   logic [payload_width_p-1:0] gap;
   logic [payload_width_p-1:0] data_r, data_n;

   // Only idle REC cycles count; cycles spent emitting records are not gaps.
   bsg_trace_recorder_gap_ctr #(.width_p(payload_width_p)) gap_ctr (
      .clk_i   (clk_i),
      .reset_i (reset_i),
      .en_i    (en_i & (state_r == REC) & ~accept),
      .clr_i   (accept),
      .count_o (gap)
   );
`endif

   always_comb begin
      state_n    = state_r;
      addr_n     = addr_r;
      fin_n      = fin_r;
      ovf_pend_n = ovf_pend_r;
      ovf_n      = ovf_r;
      mem_v_n    = mem_v_r;
      mem_addr_n = mem_addr_r;
      mem_rec_n  = mem_rec_r;
`ifdef BSG_TRACE_RECORDER_GAP_EN
      data_n     = data_r;
`endif
      if (state_r != DONE) begin
         fin_n = fin_req;
      end

      case (state_r)
         REC: begin
            // Accept beats a same-cycle finish; the sticky flag closes the
            // trace once the SEND has been written.
            if (accept) begin
               mem_v_n    = 1'b1;
               mem_addr_n = addr_r[mem_addr_width_p-1:0];
`ifdef BSG_TRACE_RECORDER_GAP_EN
               data_n = data_i;
               if (gap != '0) begin
                  state_n   = EMIT_WAIT;
                  mem_rec_n = '{op: op_wait_c, payload: gap};
               end else begin
                  state_n   = EMIT_SEND;
                  mem_rec_n = '{op: op_send_c, payload: data_i};
               end
`else
               state_n   = EMIT_SEND;
               mem_rec_n = '{op: op_send_c, payload: data_i};
`endif
            end else if (fin_req || (addr_r > addr_limit_lp)) begin
               state_n    = EMIT_FIN;
               mem_v_n    = 1'b1;
               mem_addr_n = addr_r[mem_addr_width_p-1:0];
               mem_rec_n  = '{op: op_finish_c, payload: '0};
               ovf_pend_n = ~fin_req;
            end
         end
`ifdef BSG_TRACE_RECORDER_GAP_EN
         EMIT_WAIT: begin
            if (mem_ready_i) begin
               addr_n     = addr_r + addr_one_lp;
               state_n    = EMIT_SEND;
               mem_addr_n = addr_n[mem_addr_width_p-1:0];
               mem_rec_n  = '{op: op_send_c, payload: data_r};
            end
         end
`endif
         EMIT_SEND: begin
            if (mem_ready_i) begin
               addr_n  = addr_r + addr_one_lp;
               state_n = REC;
               mem_v_n = 1'b0;
            end
         end
         EMIT_FIN: begin
            if (mem_ready_i) begin
               addr_n  = addr_r + addr_one_lp;
               state_n = DONE;
               mem_v_n = 1'b0;
               ovf_n   = ovf_pend_r;
            end
         end
         default: begin
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge reset_i) begin
      if (reset_i) begin
         state_r    <= REC;
         addr_r     <= '0;
         fin_r      <= 1'b0;
         ovf_pend_r <= 1'b0;
         ovf_r      <= 1'b0;
         mem_v_r    <= 1'b0;
         mem_addr_r <= '0;
         mem_rec_r  <= '0;
`ifdef BSG_TRACE_RECORDER_GAP_EN
         data_r     <= '0;
`endif
      end else begin
         state_r    <= state_n;
         addr_r     <= addr_n;
         fin_r      <= fin_n;
         ovf_pend_r <= ovf_pend_n;
         ovf_r      <= ovf_n;
         mem_v_r    <= mem_v_n;
         mem_addr_r <= mem_addr_n;
         mem_rec_r  <= mem_rec_n;
`ifdef BSG_TRACE_RECORDER_GAP_EN
         data_r     <= data_n;
`endif
      end
   end

   assign mem_v_o    = mem_v_r;
   assign mem_addr_o = mem_addr_r;
   assign mem_data_o = mem_rec_r;
   assign done_o     = (state_r == DONE);
   assign overflow_o = ovf_r;
   // A completely full trace (address == depth) does not fit the port width,
   // so the count pins at its maximum value.
   assign count_o    = addr_r[mem_addr_width_p] ? '1 : addr_r[mem_addr_width_p-1:0];

endmodule
